case7_vec_driver: RTL and testbench
===================================

CASE7_VEC_DRIVER -- requirements
Module: case7_vec_driver

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 Parameter SETTLE_CYCLES, default 1, SHALL set the idle cycles between applying a vector and sampling the response (range 0..15).
REQ-003 Parameter EXP_SIG, default 16'h0000, SHALL set the golden 16-bit signature compared at completion.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port start, input, 1 bit: one-cycle request to begin an exhaustive run.
REQ-007 Port abort, input, 1 bit: terminate the run in progress.
REQ-008 Ports a, b, c, d, e, f, outputs, 1 bit each: stimulus to the downstream case7 logic; a is the MSB of the vector and f the LSB.
REQ-009 Ports y1, y2, y3, inputs, 1 bit each: case7 responses.
REQ-010 Port busy, output, 1 bit: high while a run is in progress.
REQ-011 Port done, output, 1 bit: high while a completed signature is held.
REQ-012 Port pass, output, 1 bit: high when done is high and sig equals EXP_SIG.
REQ-013 Port sig, output, 16 bits: MISR signature.
REQ-014 Port vec_cnt, output, 6 bits: index of the vector currently applied.

Function
REQ-015 The FSM SHALL have the states IDLE, APPLY, WAIT, SAMPLE and DONE.
REQ-016 IDLE, or DONE, with start=1 SHALL clear vec_cnt and load sig with MISR_SEED, then go to APPLY.
REQ-017 {a,b,c,d,e,f} SHALL be registered and SHALL equal vec_cnt at all times.
REQ-018 APPLY SHALL last 1 cycle, then go to WAIT, or go directly to SAMPLE when SETTLE_CYCLES=0.
REQ-019 WAIT SHALL last exactly SETTLE_CYCLES cycles, counted by an internal 4-bit settle counter.
REQ-020 SAMPLE SHALL last 1 cycle and SHALL update sig <= {sig[14:0], fb} XOR {13'b0, y3, y2, y1}, where fb = sig[15]^sig[13]^sig[12]^sig[10].
REQ-021 In SAMPLE, if vec_cnt=63 the FSM SHALL go to DONE with vec_cnt held at 63; otherwise it SHALL increment vec_cnt and go to APPLY.
REQ-022 One run SHALL take exactly 64*(2+SETTLE_CYCLES) cycles from the start-accept edge to DONE entry (192 cycles for the default).
REQ-023 busy SHALL be 1 in APPLY, WAIT and SAMPLE, and 0 otherwise.
REQ-024 done SHALL be 1 only in DONE.
REQ-025 sig SHALL be frozen outside SAMPLE.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 abort while busy=1 SHALL move the FSM to IDLE on the next edge and clear vec_cnt; sig SHALL be left unchanged and done SHALL stay 0.
REQ-028 Simultaneous start and abort SHALL give abort priority when busy=1; in IDLE or DONE, start SHALL win.
REQ-029 abort in IDLE or DONE SHALL move the FSM to IDLE, with done deasserting the next cycle.
REQ-030 y1..y3 SHALL be sampled only in SAMPLE; their values in other states SHALL have no effect.

Reset
REQ-031 On rst=1 the FSM SHALL enter IDLE immediately (asynchronously).
REQ-032 Reset SHALL set a..f=0, vec_cnt=0, settle counter=0, sig=MISR_SEED, busy=0, done=0 and pass=0.
REQ-033 Reset asserted mid-run SHALL discard the run; after deassertion the block SHALL wait in IDLE for a new start.

Structure
REQ-034 A shared package case7_pkg SHALL hold MISR_SEED (16'h0000), the MISR tap constants, the NUM_VEC constant (64) and the FSM state enum.
REQ-035 The MISR SHALL be a separate sub-module case7_misr16, with inputs clk, rst, load, shift, din[2:0] and output q[15:0].
REQ-036 The FSM, the counters and the stimulus registers SHALL live in case7_vec_driver; there SHALL be no combinational path from y1..y3 to any output.

Verification
REQ-037 Default parameters, y1..y3 tied to 0, EXP_SIG=0, start pulsed: done SHALL rise exactly 192 cycles after the accept edge, with sig=16'h0000 and pass=1.
REQ-038 The first SAMPLE with {y3,y2,y1}=3'b101 from the seed SHALL give sig=16'h0005; a second SAMPLE with 3'b000 SHALL give sig=16'h000A.
REQ-039 Across a full run, {a..f} SHALL step 0,1,...,63 in order, each value held exactly 2+SETTLE_CYCLES cycles; SETTLE_CYCLES=0 SHALL give 128 cycles total.
REQ-040 abort at vec_cnt=20: the FSM SHALL be in IDLE with busy=0 and vec_cnt=0 next cycle, done SHALL stay 0, and a following start SHALL complete normally.
REQ-041 rst pulsed at vec_cnt=40: all outputs SHALL go to their reset values without waiting for a clock edge, and the FSM SHALL not restart without a new start.
REQ-042 Connected to the case7 netlist, a full run SHALL produce pass=1 when EXP_SIG is set to the model-computed signature, and pass=0 when one response bit is forced wrong.

Source files
------------

// File: rtl/case7_pkg.sv
// Shared constants and FSM encoding for the case7 exhaustive vector driver.
package case7_pkg;

  // MISR starts from all-zero so a fully quiet response signature stays zero.
  localparam logic [15:0] MISR_SEED = 16'h0000;
  // Feedback taps: bits 15, 13, 12 and 10.
  localparam logic [15:0] MISR_TAPS = 16'hB400;
  // 6-bit input space of the case7 logic.
  localparam int          NUM_VEC   = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/case7_misr16.sv
// 16-bit MISR compacting the three case7 response bits into a signature.
module case7_misr16
  import case7_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        shift,
  input  logic [2:0]  din,
  output logic [15:0] q
);

  logic fb;

  assign fb = ^(q & MISR_TAPS);

  // Seed on load, shift-and-fold on shift, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= MISR_SEED;
    else if (load)  q <= MISR_SEED;
    else if (shift) q <= {q[14:0], fb} ^ {13'b0, din};
  end

endmodule

// File: rtl/case7_vec_driver.sv
// Exhaustive stimulus driver for the case7 logic: walks all 64 input
// vectors, waits SETTLE_CYCLES per vector, and compacts y1..y3 into a MISR.
module case7_vec_driver
  import case7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] EXP_SIG       = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  input  logic        y1,
  input  logic        y2,
  input  logic        y3,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] sig,
  output logic [5:0]  vec_cnt
);

  localparam int          SL          = (SETTLE_CYCLES > 0) ? int'(SETTLE_CYCLES) - 1 : 0;
  localparam logic [3:0]  SETTLE_LAST = 4'(SL);
  localparam logic [5:0]  LAST_VEC    = 6'(NUM_VEC - 1);

  state_t     state, nxt;
  logic [3:0] settle_cnt;
  logic       misr_load, misr_shift;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Next-state logic; abort outranks start only while a run is active.
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start)      nxt = ST_APPLY;
        else if (abort) nxt = ST_IDLE;
      end
      ST_APPLY: begin
        if (abort)                    nxt = ST_IDLE;
        else if (SETTLE_CYCLES == 0)  nxt = ST_SAMPLE;
        else                          nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (abort)                           nxt = ST_IDLE;
        else if (settle_cnt == SETTLE_LAST)  nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)                   nxt = ST_IDLE;
        else if (vec_cnt == LAST_VEC) nxt = ST_DONE;
        else                          nxt = ST_APPLY;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Moore outputs plus MISR controls; an aborted SAMPLE must not fold.
  always_comb begin
    busy       = (state == ST_APPLY) || (state == ST_WAIT) || (state == ST_SAMPLE);
    done       = (state == ST_DONE);
    misr_load  = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    misr_shift = (state == ST_SAMPLE) && !abort;
  end

  // Vector index: cleared on accept or abort, advanced after each sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   vec_cnt <= '0;
    else if (misr_load)                        vec_cnt <= '0;
    else if (busy && abort)                    vec_cnt <= '0;
    else if (misr_shift && vec_cnt != LAST_VEC) vec_cnt <= vec_cnt + 6'd1;
  end

  // Settle counter runs only while WAIT continues into another WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   settle_cnt <= '0;
    else if (state == ST_WAIT && nxt == ST_WAIT) settle_cnt <= settle_cnt + 4'd1;
    else                                       settle_cnt <= '0;
  end

  case7_misr16 u_misr (
    .clk   (clk),
    .rst   (rst),
    .load  (misr_load),
    .shift (misr_shift),
    .din   ({y3, y2, y1}),
    .q     (sig)
  );

  // Stimulus is the vector counter register itself, so it is glitch-free.
  assign {a, b, c, d, e, f} = vec_cnt;
  assign pass = done && (sig == EXP_SIG);

endmodule

// File: tb/tb_case7_vec_driver.sv
// Scoreboard bench: two drivers (settle 1 and settle 0) run against a
// random case7 response table; expected signatures come from a loop model.
module tb_case7_vec_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] tbl [64];

  logic        a0, b0, c0, d0, e0, f0, busy0, done0, pass0;
  logic        a1, b1, c1, d1, e1, f1, busy1, done1, pass1;
  logic [15:0] sig0, sig1;
  logic [5:0]  vec0, vec1;
  logic [2:0]  r0, r1;

  // Downstream "case7 logic" stand-in: a lookup on the applied vector.
  assign r0 = tbl[{a0, b0, c0, d0, e0, f0}];
  assign r1 = tbl[{a1, b1, c1, d1, e1, f1}];

  case7_vec_driver #(.SETTLE_CYCLES(1), .EXP_SIG(16'h0000)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0),
    .y1(r0[0]), .y2(r0[1]), .y3(r0[2]),
    .busy(busy0), .done(done0), .pass(pass0), .sig(sig0), .vec_cnt(vec0));

  case7_vec_driver #(.SETTLE_CYCLES(0), .EXP_SIG(16'h0000)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1),
    .y1(r1[0]), .y2(r1[1]), .y3(r1[2]),
    .busy(busy1), .done(done1), .pass(pass1), .sig(sig1), .vec_cnt(vec1));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    int          acc;
    int          len;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference signature: serial polynomial division over the 64 responses.
  function automatic logic [15:0] model_sig();
    logic [15:0] s = 16'h0000;
    for (int v = 0; v < 64; v++) begin
      logic fb;
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      s  = {s[14:0], fb} ^ {13'b0, tbl[v]};
    end
    return s;
  endfunction

  // Completion monitor: pop expected result whenever done rises.
  logic pd0 = 1'b0, pd1 = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (done0 && !pd0) begin
      if (q0.size() == 0) chk("u0_unexpected_done", 1, 0);
      else begin
        x = q0.pop_front();
        chk("u0_sig", sig0, x.sig);
        chk("u0_pass", pass0, x.pass);
        chk("u0_run_len", cyc - x.acc, x.len);
      end
    end
    if (done1 && !pd1) begin
      if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
      else begin
        x = q1.pop_front();
        chk("u1_sig", sig1, x.sig);
        chk("u1_pass", pass1, x.pass);
        chk("u1_run_len", cyc - x.acc, x.len);
      end
    end
    pd0 <= done0;
    pd1 <= done1;
  end

  // Vector-walk monitor: each busy vector steps by one and is held 2+S cycles.
  int   hold [2];
  logic [5:0] lastv [2];
  logic lastb [2];
  always @(negedge clk) begin
    logic [5:0] v [2];
    logic       bz [2];
    v[0] = vec0; v[1] = vec1; bz[0] = busy0; bz[1] = busy1;
    for (int i = 0; i < 2; i++) begin
      if (bz[i]) begin
        if (!lastb[i]) hold[i] = 1;
        else if (v[i] != lastv[i]) begin
          chk(i == 0 ? "u0_vec_step" : "u1_vec_step", v[i], lastv[i] + 6'd1);
          chk(i == 0 ? "u0_vec_hold" : "u1_vec_hold", hold[i], i == 0 ? 3 : 2);
          hold[i] = 1;
        end else hold[i]++;
      end
      lastv[i] = v[i];
      lastb[i] = bz[i];
    end
  end

  // Pulse start; when a completion is expected, push both scoreboard entries.
  task automatic do_start(input bit expect_done);
    exp_t x;
    logic [15:0] s;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (expect_done) begin
      s = model_sig();
      x.sig = s; x.pass = (s == 16'h0000); x.acc = cyc;
      x.len = 64 * 3; q0.push_back(x);
      x.len = 64 * 2; q1.push_back(x);
    end
  endtask

  task automatic wait_done0();
    int k = 0;
    while (!done0 && k < 400) begin @(negedge clk); k++; end
    if (!done0) chk("u0_done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_vec0(input logic [5:0] t);
    int k = 0;
    @(negedge clk);
    while (vec0 != t && k < 400) begin @(negedge clk); k++; end
    if (vec0 != t) chk("u0_vec_timeout", vec0, t);
  endtask

  task automatic fill_rand();
    for (int v = 0; v < 64; v++) tbl[v] = 3'($urandom_range(0, 7));
  endtask

  initial begin
    lastb[0] = 0; lastb[1] = 0; hold[0] = 0; hold[1] = 0;
    for (int v = 0; v < 64; v++) tbl[v] = 3'b000;
    #12;
    chk("rst_busy", {busy0, busy1}, 2'b00);
    chk("rst_done_pass", {done0, pass0, done1, pass1}, 4'b0);
    chk("rst_sig", {sig0, sig1}, 32'h0);
    chk("rst_vec", {a0, b0, c0, d0, e0, f0, vec1}, 12'h0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    // Quiet responses: signature stays at seed and passes.
    do_start(1);
    wait_done0();

    // Directed first two samples: 101 then 000.
    tbl[0] = 3'b101;
    do_start(1);
    repeat (2) @(posedge clk); #1 chk("u1_sig_first", sig1, 16'h0005);
    @(posedge clk);            #1 chk("u0_sig_first", sig0, 16'h0005);
    @(posedge clk);            #1 chk("u1_sig_second", sig1, 16'h000A);
    repeat (2) @(posedge clk); #1 chk("u0_sig_second", sig0, 16'h000A);
    wait_done0();

    // Random response tables, one with a stray start mid-run.
    for (int r = 0; r < 4; r++) begin
      fill_rand();
      do_start(1);
      if (r == 1) begin
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
      end
      wait_done0();
    end

    // Abort (with simultaneous start) at vector 20.
    fill_rand();
    do_start(0);
    wait_vec0(6'd20);
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    chk("abort_busy", {busy0, busy1}, 2'b00);
    chk("abort_vec", {vec0, vec1}, 12'h0);
    chk("abort_done", {done0, done1}, 2'b00);
    fill_rand();
    do_start(1);
    wait_done0();

    // Abort while DONE returns to idle.
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_in_done", {done0, done1, pass0, pass1}, 4'b0);

    // Asynchronous reset at vector 40.
    fill_rand();
    do_start(0);
    wait_vec0(6'd40);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {busy0, busy1, done0, done1, pass0, pass1}, 6'b0);
    chk("arst_vec", {a0, b0, c0, d0, e0, f0, vec0, vec1}, 18'h0);
    chk("arst_sig", {sig0, sig1}, 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("arst_no_restart", {busy0, busy1, done0, done1}, 4'b0);

    fill_rand();
    do_start(1);
    wait_done0();
    repeat (3) @(negedge clk);
    chk("q_drained", q0.size() + q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
